// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-back front end.
// Load entries carry everything needed to align and extend at the FIFO output.
package regfile_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam int unsigned WIDTH_W        = 4;
  localparam int unsigned OFFSET_W       = 2;

  localparam logic [WIDTH_W-1:0] WRITE_WIDTH_BYTE = 4'd1;
  localparam logic [WIDTH_W-1:0] WRITE_WIDTH_HALF = 4'd2;
  localparam logic [WIDTH_W-1:0] WRITE_WIDTH_WORD = 4'd4;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [WIDTH_W-1:0]        width;
    logic                      is_unsigned;
    logic [OFFSET_W-1:0]       offset;
    logic [XLEN-1:0]           raw;
  } ld_entry_t;

  // Any width encoding other than byte/half is handled as a full word.
  function automatic logic [WIDTH_W-1:0] norm_width(input logic [WIDTH_W-1:0] w);
    case (w)
      WRITE_WIDTH_BYTE: norm_width = WRITE_WIDTH_BYTE;
      WRITE_WIDTH_HALF: norm_width = WRITE_WIDTH_HALF;
      default:          norm_width = WRITE_WIDTH_WORD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract_load(input ld_entry_t e);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(e.raw >> {e.offset, 3'b000});
    h = e.offset[1] ? e.raw[31:16] : e.raw[15:0];
    case (norm_width(e.width))
      WRITE_WIDTH_BYTE:
        extract_load = e.is_unsigned ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      WRITE_WIDTH_HALF:
        extract_load = e.is_unsigned ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default:
        extract_load = e.raw;
    endcase
  endfunction

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Bundle of ALU/load result channels, scoreboard issue port and RF write port.
interface regfile_writeback_unit_if;
  import regfile_pkg::*;

  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [XLEN-1:0]           alu_data;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [WIDTH_W-1:0]        ld_width;
  logic                      ld_unsigned;
  logic [OFFSET_W-1:0]       ld_byte_offset;
  logic [XLEN-1:0]           ld_raw_data;

  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic [NUM_REGS-1:0]       pending_mask;

  logic                      rf_write_enable;
  logic [WIDTH_W-1:0]        rf_write_width;
  logic [REG_ADDR_WIDTH-1:0] rf_write_reg_addr;
  logic [XLEN-1:0]           rf_write_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_width, ld_unsigned, ld_byte_offset, ld_raw_data,
    input  issue_valid, issue_rd,
    output alu_ready, ld_ready, pending_mask,
    output rf_write_enable, rf_write_width, rf_write_reg_addr, rf_write_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_width, ld_unsigned, ld_byte_offset, ld_raw_data,
    output issue_valid, issue_rd,
    input  alu_ready, ld_ready, pending_mask,
    input  rf_write_enable, rf_write_width, rf_write_reg_addr, rf_write_data
  );
endinterface

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO of pending load results; head is visible combinationally.
module wb_load_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  ld_entry_t push_data,
  input  logic      pop,
  output ld_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  ld_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Merges ALU and load results onto the single RF write port, with load starvation guard.
// Optional pending-register scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_writeback_unit
  import regfile_pkg::*;
#(
  parameter int unsigned LD_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_writeback_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  ld_entry_t                 push_entry;
  ld_entry_t                 head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      alu_win;
  logic                      alu_ready;
  logic [XLEN-1:0]           load_data;
  logic [CNT_W-1:0]          starve_q;
  logic [CNT_W-1:0]          starve_d;

  logic                      wen_q;
  logic [WIDTH_W-1:0]        width_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]           data_q;

  assign push_entry = '{rd:          bus.ld_rd,
                        width:       bus.ld_width,
                        is_unsigned: bus.ld_unsigned,
                        offset:      bus.ld_byte_offset,
                        raw:         bus.ld_raw_data};

  // ALU is held off for one cycle once the waiting load has lost STARVE_LIMIT times.
  assign alu_ready = (starve_q != CNT_W'(STARVE_LIMIT));
  assign alu_win   = bus.alu_valid && alu_ready;
  assign pop       = !alu_win && !fifo_empty;
  assign push      = bus.ld_valid && !fifo_full;
  assign load_data = extract_load(head);

  assign bus.alu_ready = alu_ready;
  assign bus.ld_ready  = !fifo_full;

  wb_load_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) starve_d = '0;
    else if (alu_win)      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  // x0 results are consumed normally but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (alu_win) begin
      wen_q   <= (bus.alu_rd != '0);
      width_q <= WRITE_WIDTH_WORD;
      addr_q  <= bus.alu_rd;
      data_q  <= bus.alu_data;
    end else if (pop) begin
      wen_q   <= (head.rd != '0);
      width_q <= norm_width(head.width);
      addr_q  <= head.rd;
      data_q  <= load_data;
    end else begin
      wen_q   <= 1'b0;
    end
  end

  assign bus.rf_write_enable   = wen_q;
  assign bus.rf_write_width    = width_q;
  assign bus.rf_write_reg_addr = addr_q;
  assign bus.rf_write_data     = data_q;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Set is applied after clear so a same-cycle reissue keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) pending_d[addr_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pending_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign bus.pending_mask = pending_q;
`else
  logic unused_issue;
  assign unused_issue     = ^{bus.issue_valid, bus.issue_rd};
  assign bus.pending_mask = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit (STARVE_LIMIT=4); honours WB_SCOREBOARD_EN.
module tb_regfile_writeback_unit;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  regfile_writeback_unit_if bus();

  regfile_writeback_unit #(
    .LD_FIFO_DEPTH (4),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [3:0] w, input logic uns,
                          input logic [1:0] off, input logic [31:0] raw);
    bus.ld_valid       = 1'b1;
    bus.ld_rd          = rd;
    bus.ld_width       = w;
    bus.ld_unsigned    = uns;
    bus.ld_byte_offset = off;
    bus.ld_raw_data    = raw;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] d,
                             input logic [3:0] w);
    check({tag, "_en"},   32'(bus.rf_write_enable),   32'd1);
    check({tag, "_addr"}, 32'(bus.rf_write_reg_addr), 32'(rd));
    check({tag, "_data"}, bus.rf_write_data,          d);
    check({tag, "_w"},    32'(bus.rf_write_width),    32'(w));
  endtask

  // Push one load into an empty FIFO with the ALU idle: write appears two edges later.
  task automatic load_case(input string tag, input logic [4:0] rd, input logic [3:0] w,
                           input logic uns, input logic [1:0] off, input logic [31:0] raw,
                           input logic [31:0] exp_d, input logic [3:0] exp_w);
    set_load(rd, w, uns, off, raw);
    tick();
    bus.ld_valid = 1'b0;
    check({tag, "_lat"}, 32'(bus.rf_write_enable), 32'd0);
    tick();
    check_write(tag, rd, exp_d, exp_w);
    tick();
  endtask

  int low_cnt;
  int alu_before;
  int load_seen;

  initial begin
    reset           = 1'b1;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_width    = '0;
    bus.ld_unsigned = 1'b0;
    bus.ld_byte_offset = '0;
    bus.ld_raw_data = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;

    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_wen",     32'(bus.rf_write_enable), 32'd0);
    check("rst_pending", bus.pending_mask,         32'd0);
    check("rst_ldrdy",   32'(bus.ld_ready),        32'd1);
    check("rst_alurdy",  32'(bus.alu_ready),       32'd1);

    // ALU write, one cycle latency, then idle hold
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    check_write("alu", 5'd5, 32'hDEADBEEF, 4'd4);
    tick();
    check("idle_wen",  32'(bus.rf_write_enable),   32'd0);
    check("idle_addr", 32'(bus.rf_write_reg_addr), 32'd5);
    check("idle_data", bus.rf_write_data,          32'hDEADBEEF);

    // load alignment / extension vectors
    load_case("lb_s",  5'd1, 4'd1, 1'b0, 2'd2, 32'h12F45678, 32'hFFFFFFF4, 4'd1);
    load_case("lb_u",  5'd2, 4'd1, 1'b1, 2'd2, 32'h12F45678, 32'h000000F4, 4'd1);
    load_case("lh_s",  5'd3, 4'd2, 1'b0, 2'd2, 32'h80010000, 32'hFFFF8001, 4'd2);
    load_case("lw",    5'd4, 4'd4, 1'b0, 2'd3, 32'h01020304, 32'h01020304, 4'd4);
    load_case("lh_u3", 5'd6, 4'd2, 1'b1, 2'd3, 32'hABCD1234, 32'h0000ABCD, 4'd2);
    load_case("lb_s0", 5'd8, 4'd1, 1'b0, 2'd0, 32'h0000807F, 32'h0000007F, 4'd1);
    load_case("lbad",  5'd9, 4'd3, 1'b0, 2'd1, 32'h89ABCDEF, 32'h89ABCDEF, 4'd4);

    // starvation: one queued load, ALU valid every cycle
    set_load(5'd11, 4'd1, 1'b1, 2'd0, 32'h000000AA);
    tick();
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd10;
    bus.alu_data  = 32'h0000A1A1;
    low_cnt    = 0;
    alu_before = 0;
    load_seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.alu_ready) low_cnt++;
      tick();
      if (bus.rf_write_enable && bus.rf_write_reg_addr == 5'd11) begin
        load_seen++;
        check("starve_ld_data", bus.rf_write_data, 32'h000000AA);
        check("starve_ld_w",    32'(bus.rf_write_width), 32'd1);
      end else if (bus.rf_write_enable && bus.rf_write_reg_addr == 5'd10 && load_seen == 0) begin
        alu_before++;
      end
    end
    check("starve_low",  32'(low_cnt),    32'd1);
    check("starve_alu",  32'(alu_before), 32'd4);
    check("starve_seen", 32'(load_seen),  32'd1);
    bus.alu_valid = 1'b0;
    tick();

    // FIFO fills while ALU is busy
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd20;
    bus.alu_data  = 32'h00002020;
    for (int i = 0; i < 4; i++) begin
      set_load(5'(12 + i), 4'd4, 1'b0, 2'd0, 32'h1000 + 32'(i));
      tick();
    end
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b0;
    check("full_ldrdy",  32'(bus.ld_ready),  32'd0);
    check("full_alurdy", 32'(bus.alu_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_write("drain", 5'(12 + i), 32'h1000 + 32'(i), 4'd4);
    end
    check("drain_ldrdy", 32'(bus.ld_ready), 32'd1);
    tick();

    // rd=0 results never raise the enable
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h55555555;
    tick();
    bus.alu_valid = 1'b0;
    check("alu_x0_wen", 32'(bus.rf_write_enable), 32'd0);
    set_load(5'd0, 4'd4, 1'b0, 2'd0, 32'h66666666);
    tick();
    bus.ld_valid = 1'b0;
    tick();
    check("ld_x0_wen",   32'(bus.rf_write_enable), 32'd0);
    check("ld_x0_ldrdy", 32'(bus.ld_ready),        32'd1);
    tick();

    // scoreboard: issue rd=7 while a write to x7 is on the port
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h00000077;
    tick();
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    check_write("sb_alu", 5'd7, 32'h00000077, 4'd4);
    tick();
    bus.issue_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
    check("sb_set_wins", 32'(bus.pending_mask[7]), 32'd1);
    bus.alu_valid   = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    tick();
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b0;
    tick();
    check("sb_clear", bus.pending_mask, 32'd0);
`else
    check("sb_tied0", bus.pending_mask, 32'd0);
`endif

    // reset mid-operation drops in-flight write and queued load
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h33333333;
    set_load(5'd4, 4'd4, 1'b0, 2'd0, 32'h44444444);
    tick();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    check("mid_alu_wen", 32'(bus.rf_write_enable), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_wen", 32'(bus.rf_write_enable), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_post1_wen", 32'(bus.rf_write_enable), 32'd0);
    tick();
    check("mid_post2_wen", 32'(bus.rf_write_enable), 32'd0);
    check("mid_ldrdy",     32'(bus.ld_ready),        32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
